// File: rtl/wbs_bridge_pkg.sv
// wbs_bridge_pkg: shared constants, FSM state type and byte-lane merge for the Wishbone memory bridge.
package wbs_bridge_pkg;
    localparam logic [7:0] WBS_CTRL_REGION = 8'h30;
    localparam logic [7:0] WBS_BANK_BASE = 8'h31;
    localparam logic [23:0] CTRL_MODE = 24'h0;
    localparam logic [23:0] CTRL_DEBUG = 24'h1;
    localparam logic [23:0] CTRL_ID = 24'h2;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_CAP, ACK} wbs_state_e;

    function automatic logic [31:0] merge_beat(input logic [31:0] old, input logic [31:0] din, input logic [3:0] sel);
        logic [31:0] m;
        m = old;
        for (int i = 0; i < 4; i++)
            m[8*i +: 8] = sel[i] ? din[8*i +: 8] : old[8*i +: 8];
        return m;
    endfunction
endpackage

// File: rtl/wbs_beat_stager.sv
// wbs_beat_stager: per-beat staging of a wide bank word with byte-lane merge.
module wbs_beat_stager
    import wbs_bridge_pkg::*;
#(
    parameter int WORD_WIDTH = 64,
    parameter int BEATS = 2,
    parameter int BEAT_BITS = 1
) (
    input logic clk,
    input logic rst,
    input logic wr,
    input logic [BEAT_BITS-1:0] beat,
    input logic [31:0] din,
    input logic [3:0] sel,
    output logic [WORD_WIDTH-1:0] word
);
    logic [BEATS*32-1:0] staging;

    // The final beat merges into the top slot too; the commit word is staging truncated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            staging <= '0;
        else if (wr)
            staging[32*beat +: 32] <= merge_beat(staging[32*beat +: 32], din, sel);
    end

    assign word = staging[WORD_WIDTH-1:0];
endmodule

// File: rtl/wbs_mem_bridge.sv
// wbs_mem_bridge: Wishbone classic slave exposing control registers and NUM_BANKS wide SRAM banks.
module wbs_mem_bridge
    import wbs_bridge_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int WORD_WIDTH = 64,
    parameter int BANK_ADDRW = 6,
    parameter logic [31:0] ID_VALUE = 32'h5742_0001
) (
    input logic wb_clk_i,
    input logic wb_rst_i,
    input logic wbs_stb_i,
    input logic wbs_cyc_i,
    input logic wbs_we_i,
    input logic [3:0] wbs_sel_i,
    input logic [31:0] wbs_dat_i,
    input logic [31:0] wbs_adr_i,
    output logic wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic wbs_mode,
    output logic wbs_debug,
    output logic [NUM_BANKS-1:0] mem_csb,
    output logic [NUM_BANKS-1:0] mem_web,
    output logic [BANK_ADDRW-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input logic [NUM_BANKS*WORD_WIDTH-1:0] mem_rdata
);
    localparam int BEATS = (WORD_WIDTH + 31) / 32;
    localparam int BEAT_BITS = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int BANK_BITS = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    localparam int PADW = BEATS * 32;

    wbs_state_e state, next;
    logic [BANK_BITS-1:0] bank_q;
    logic [BEAT_BITS-1:0] beat_q;
    logic commit_q;
    logic [7:0] region, bank_off;
    logic [23:0] word;
    logic [BEAT_BITS-1:0] beat;
    logic is_ctrl, is_bank, bank_go, last_beat, accept;
    logic [31:0] ctrl_rd, rd_beat;
    logic [PADW-1:0] rd_pad;
    logic [NUM_BANKS-1:0] bank_mask;

    always_comb begin
        region = wbs_adr_i[31:24];
        word = wbs_adr_i[23:0];
        beat = wbs_adr_i[BEAT_BITS-1:0];
        bank_off = region - WBS_BANK_BASE;
        is_ctrl = region == WBS_CTRL_REGION;
        is_bank = region >= WBS_BANK_BASE && int'(bank_off) < NUM_BANKS;
        bank_go = is_bank && int'(beat) < BEATS && wbs_debug;
        last_beat = int'(beat) == BEATS - 1;
        accept = state == IDLE && wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
        ctrl_rd = word == CTRL_MODE ? {31'b0, wbs_mode} :
                  word == CTRL_DEBUG ? {31'b0, wbs_debug} :
                  word == CTRL_ID ? ID_VALUE : 32'h0;
        rd_pad = PADW'(mem_rdata[int'(bank_q)*WORD_WIDTH +: WORD_WIDTH]);
        rd_beat = rd_pad[32*beat_q +: 32];
        bank_mask = NUM_BANKS'(1) << bank_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: next = accept ? (bank_go && !wbs_we_i ? RD_REQ : ACK) : IDLE;
            RD_REQ: next = RD_CAP;
            RD_CAP: next = ACK;
            ACK: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = state == ACK;
        mem_csb = (state == RD_REQ || (state == ACK && commit_q)) ? ~bank_mask : '1;
        mem_web = (state == ACK && commit_q) ? ~bank_mask : '1;
    end

    // Gated, unmapped and out-of-range reads all return zero; writes only touch mapped targets.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_dat_o <= '0;
            wbs_mode <= 1'b0;
            wbs_debug <= 1'b0;
            mem_addr <= '0;
            bank_q <= '0;
            beat_q <= '0;
            commit_q <= 1'b0;
        end else begin
            if (accept) begin
                bank_q <= bank_off[BANK_BITS-1:0];
                beat_q <= beat;
                commit_q <= bank_go && wbs_we_i && last_beat;
                if (bank_go)
                    mem_addr <= wbs_adr_i[BEAT_BITS +: BANK_ADDRW];
                if (!wbs_we_i && !bank_go)
                    wbs_dat_o <= is_ctrl ? ctrl_rd : 32'h0;
                if (wbs_we_i && is_ctrl && wbs_sel_i[0]) begin
                    if (word == CTRL_MODE)
                        wbs_mode <= wbs_dat_i[0];
                    if (word == CTRL_DEBUG)
                        wbs_debug <= wbs_dat_i[0];
                end
            end
            if (state == RD_CAP)
                wbs_dat_o <= rd_beat;
        end
    end

    wbs_beat_stager #(
        .WORD_WIDTH(WORD_WIDTH),
        .BEATS(BEATS),
        .BEAT_BITS(BEAT_BITS)
    ) u_stager (
        .clk(wb_clk_i),
        .rst(wb_rst_i),
        .wr(accept && bank_go && wbs_we_i),
        .beat(beat),
        .din(wbs_dat_i),
        .sel(wbs_sel_i),
        .word(mem_wdata)
    );
endmodule

// File: tb/tb_wbs_mem_bridge.sv
// tb_wbs_mem_bridge: directed checks of register, bank read/write, gating and reset behaviour.
module tb_wbs_mem_bridge;
    logic clk = 1'b0;
    logic rst, cyc, stb, we, ack, mode, debug;
    logic [3:0] sel;
    logic [31:0] wdat, adr, rdat;
    logic [7:0] csb, web;
    logic [5:0] maddr;
    logic [63:0] mwdata;
    logic [511:0] mrdata;

    int n_checks = 0;
    int n_errors = 0;
    int csb_tot [8];
    int web_tot [8];
    int csb_base [8];
    int web_base [8];
    logic [5:0] cap_addr = '0;
    logic [63:0] cap_wdata = '0;

    always #5 clk = ~clk;

    wbs_mem_bridge dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i(we),
        .wbs_sel_i(sel),
        .wbs_dat_i(wdat),
        .wbs_adr_i(adr),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .wbs_mode(mode),
        .wbs_debug(debug),
        .mem_csb(csb),
        .mem_web(web),
        .mem_addr(maddr),
        .mem_wdata(mwdata),
        .mem_rdata(mrdata)
    );

    initial for (int b = 0; b < 8; b++) begin
        csb_tot[b] = 0;
        web_tot[b] = 0;
    end

    always @(negedge clk)
        for (int b = 0; b < 8; b++) begin
            if (!csb[b]) csb_tot[b]++;
            if (!web[b]) begin
                web_tot[b]++;
                cap_addr = maddr;
                cap_wdata = mwdata;
            end
        end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        for (int b = 0; b < 8; b++) begin
            csb_base[b] = csb_tot[b];
            web_base[b] = web_tot[b];
        end
    endtask

    function automatic int csb_delta(input int skip);
        int s = 0;
        for (int b = 0; b < 8; b++) if (b != skip) s += csb_tot[b] - csb_base[b];
        return s;
    endfunction

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int lat, output logic ack2);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        lat = 0;
        rd = 'x;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 10);
        if (ack) rd = rdat;
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        ack2 = ack;
    endtask

    logic [31:0] rd;
    int lat, acks;
    logic ack2;

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; wdat = 0; adr = 0;
        mrdata = '0;
        for (int b = 0; b < 8; b++) mrdata[b*64 +: 64] = {32'hB000_0000 | b, 32'hA000_0000 | b};
        mrdata[7*64 +: 64] = 64'h1100_1010_DEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_mode", mode, 0);
        chk("rst_debug", debug, 0);
        chk("rst_csb", csb, 8'hFF);
        chk("rst_web", web, 8'hFF);
        chk("rst_addr", maddr, 0);
        chk("rst_wdata", mwdata, 0);
        @(negedge clk) rst = 0;

        xfer(1, 32'h3000_0000, 32'h1, 4'hF, rd, lat, ack2);
        chk("mode_lat", lat, 1);
        chk("mode_ack1", ack2, 0);
        chk("mode_val", mode, 1);
        xfer(1, 32'h3000_0001, 32'h1, 4'hF, rd, lat, ack2);
        chk("debug_lat", lat, 1);
        chk("debug_val", debug, 1);
        xfer(1, 32'h3000_0000, 32'h0, 4'hE, rd, lat, ack2);
        chk("mode_sel0", mode, 1);
        xfer(0, 32'h3000_0002, 32'h0, 4'hF, rd, lat, ack2);
        chk("id_lat", lat, 1);
        chk("id_val", rd, 32'h5742_0001);
        xfer(0, 32'h3000_0000, 32'h0, 4'hF, rd, lat, ack2);
        chk("mode_rd", rd, 1);

        mark();
        xfer(0, 32'h3800_0002, 32'h0, 4'hF, rd, lat, ack2);
        chk("rd7_lat", lat, 3);
        chk("rd7_beat0", rd, 32'hDEAD_BEEF);
        chk("rd7_ack1", ack2, 0);
        chk("rd7_csb", csb_tot[7] - csb_base[7], 1);
        chk("rd7_web", web_tot[7] - web_base[7], 0);
        chk("rd7_other", csb_delta(7), 0);
        chk("rd7_addr", maddr, 1);
        xfer(0, 32'h3800_0003, 32'h0, 4'hF, rd, lat, ack2);
        chk("rd7_beat1", rd, 32'h1100_1010);
        xfer(0, 32'h3200_0005, 32'h0, 4'hF, rd, lat, ack2);
        chk("rd1_beat1", rd, 32'hB000_0001);

        mark();
        xfer(1, 32'h3400_0006, 32'h7654_3210, 4'hF, rd, lat, ack2);
        chk("wr3_b0_lat", lat, 1);
        chk("wr3_b0_idle", csb_delta(-1), 0);
        xfer(1, 32'h3400_0007, 32'hFEDC_BA98, 4'hF, rd, lat, ack2);
        chk("wr3_b1_lat", lat, 1);
        chk("wr3_csb", csb_tot[3] - csb_base[3], 1);
        chk("wr3_web", web_tot[3] - web_base[3], 1);
        chk("wr3_other", csb_delta(3), 0);
        chk("wr3_addr", cap_addr, 3);
        chk("wr3_wdata", cap_wdata, 64'hFEDC_BA98_7654_3210);
        chk("wr3_dat_hold", rdat, 32'hB000_0001);

        xfer(1, 32'h3100_0000, 32'h1234_5678, 4'hF, rd, lat, ack2);
        xfer(1, 32'h3100_0000, 32'hAAAA_AAAA, 4'h3, rd, lat, ack2);
        mark();
        xfer(1, 32'h3100_0001, 32'h0, 4'hF, rd, lat, ack2);
        chk("wr0_web", web_tot[0] - web_base[0], 1);
        chk("wr0_wdata", cap_wdata, 64'h0000_0000_1234_AAAA);

        xfer(1, 32'h3000_0001, 32'h0, 4'hF, rd, lat, ack2);
        chk("debug_off", debug, 0);
        mark();
        xfer(0, 32'h3800_0002, 32'h0, 4'hF, rd, lat, ack2);
        chk("gate_rd_lat", lat, 1);
        chk("gate_rd_dat", rd, 0);
        xfer(1, 32'h3100_0000, 32'hFFFF_FFFF, 4'hF, rd, lat, ack2);
        chk("gate_wr_lat", lat, 1);
        xfer(1, 32'h3100_0001, 32'hFFFF_FFFF, 4'hF, rd, lat, ack2);
        chk("gate_csb", csb_delta(-1), 0);
        xfer(0, 32'h3000_0002, 32'h0, 4'hF, rd, lat, ack2);
        xfer(0, 32'h3F00_0000, 32'h0, 4'hF, rd, lat, ack2);
        chk("unmap_rd_lat", lat, 1);
        chk("unmap_rd_dat", rd, 0);
        xfer(1, 32'h3F00_0000, 32'hFFFF_FFFF, 4'hF, rd, lat, ack2);
        chk("unmap_wr_lat", lat, 1);
        chk("unmap_csb", csb_delta(-1), 0);

        xfer(1, 32'h3000_0001, 32'h1, 4'hF, rd, lat, ack2);
        mark();
        xfer(1, 32'h3100_0001, 32'h5555_5555, 4'hF, rd, lat, ack2);
        chk("stage_kept", cap_wdata, 64'h5555_5555_1234_AAAA);
        chk("stage_addr", cap_addr, 0);

        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3800_0002; sel = 4'hF;
        @(posedge clk); #1;
        chk("rdreq_csb", csb, 8'h7F);
        #1 rst = 1;
        #1;
        chk("arst_csb", csb, 8'hFF);
        chk("arst_ack", ack, 0);
        chk("arst_debug", debug, 0);
        chk("arst_mode", mode, 0);
        chk("arst_addr", maddr, 0);
        cyc = 0; stb = 0;
        @(negedge clk) rst = 0;
        acks = 0;
        repeat (4) @(negedge clk) if (ack) acks++;
        chk("arst_noack", acks, 0);
        xfer(0, 32'h3000_0002, 32'h0, 4'hF, rd, lat, ack2);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_id", rd, 32'h5742_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
